fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Program-counter and fetch-control stage directly upstream of the byte-addressed instruction memory.
- Drives the memory byte address, which the memory samples on the falling clock edge and returns as a big-endian 32-bit word by the next rising edge.
- Handles sequential increment, stall, jump/branch redirect, halt detection on the returned word, and a fetch-valid flag for the IF/ID register.

Parameters:
- bitsDir, 32, address and instruction width.
- MEM_BYTES, 128, instruction memory size in bytes; power of two, multiple of 4.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit freeze request.
- jump  input  1  unconditional redirect request.
- jump_target  input  bitsDir  jump byte address.
- branch_taken  input  1  resolved taken-branch redirect request.
- branch_target  input  bitsDir  branch byte address.
- instruction  input  bitsDir  word returned by memory for the current Addr.
- Addr  output  bitsDir  current PC, fed to the instruction memory.
- pc_plus4  output  bitsDir  (Addr+4) mod MEM_BYTES, combinational.
- fetch_valid  output  1  instruction at Addr is valid for IF/ID capture this cycle.
- halted  output  1  HALT_WORD fetched; PC frozen.
- misaligned  output  1  sticky flag: a redirect target had bits[1:0] non-zero.

Behaviour:
- Clock and reset: one clock, clk, rising edge; reset is synchronous and active-high.
- Reset values: Addr=0, fetch_valid=0, halted=0, misaligned=0, state=IDLE.
- States: IDLE, RUN, STALL, HALT.
- IDLE: entered only via reset. Next cycle goes to RUN with Addr held at 0, fetch_valid=1.
- Priority each rising edge: reset > HALT > redirect > stall > increment.
- RUN, instruction==HALT_WORD and no redirect: go to HALT; Addr holds; fetch_valid=0; halted=1.
- RUN, redirect: jump has priority over branch_taken if both are high. Addr <= target with bits[1:0] forced to 0, taken modulo MEM_BYTES. fetch_valid=0 for exactly one cycle (flush bubble). misaligned is set if target[1:0]!=0.
- RUN, stall (no redirect): go to STALL; Addr holds; fetch_valid=0.
- RUN, otherwise: Addr <= pc_plus4; fetch_valid=1.
- STALL, stall still high: Addr holds, no halt check.
- STALL, stall low: return to RUN with the same Addr (the word is refetched); fetch_valid=1.
- STALL, redirect: redirect overrides stall (same action as in RUN); state returns to RUN.
- HALT: absorbing state until reset. Ignores stall, jump and branch; Addr frozen.
- Halt detection: active only in RUN, and never in the flush-bubble cycle after a redirect, because instruction is stale then.
- Wrap-around: Addr=MEM_BYTES-4 increments to 0. Targets at or above MEM_BYTES wrap modulo MEM_BYTES.
- Address width: Addr bits above log2(MEM_BYTES) are always 0.
- Reset mid-operation (any state, including HALT): next edge gives reset values, then IDLE->RUN.
- Latency: a redirect asserted at edge N gives Addr=target after edge N. The first valid target word is flagged at edge N+1.

Optional Feature:
- Macro: FETCH_STEP_EN.
- Defined: adds input step (1 bit) and input step_mode (1 bit).
  - When step_mode=1, RUN behaves as STALL except in the cycle where step=1.
  - In that cycle there is one increment (or redirect) with fetch_valid=1, for debug-unit single-stepping.
  - Halt detection is unchanged.
  - step_mode=0 gives normal behaviour.
- Not defined: ports are absent; behaviour is exactly as in Behaviour.

Test Plan:
- Reset then 5 free-running cycles with non-halt words -> Addr 0,4,8,12,16; fetch_valid=1 after the IDLE cycle; halted=0.
- Addr=8, stall high for 3 cycles -> Addr stays 8 with fetch_valid=0; after release fetch_valid=1 at Addr 8, then 12.
- jump=1 with jump_target=0x40 and branch_taken=1 with branch_target=0x20 in the same cycle -> Addr=0x40; one bubble cycle; misaligned=0.
- branch_target=0x23 -> Addr=0x20; misaligned=1 and stays 1 until reset.
- Addr=124 (MEM_BYTES=128) incremented -> Addr=0; jump_target=0x90 -> Addr=0x10.
- instruction=32'hFFFFFFFF at Addr 12 -> halted=1, Addr stays 12 under stall/jump toggling; reset -> Addr=0, halted=0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : PC / fetch control ahead of the byte-addressed instruction
//               memory: increment, stall, jump/branch redirect, halt detect.
//               Optional macro FETCH_STEP_EN adds debug single-step inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter int                 bitsDir   = 32,
    parameter int                 MEM_BYTES = 128,
    parameter logic [bitsDir-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               jump,
    input  logic [bitsDir-1:0] jump_target,
    input  logic               branch_taken,
    input  logic [bitsDir-1:0] branch_target,
    input  logic [bitsDir-1:0] instruction,
`ifdef FETCH_STEP_EN
    input  logic               step,
    input  logic               step_mode,
`endif
    output logic [bitsDir-1:0] Addr,
    output logic [bitsDir-1:0] pc_plus4,
    output logic               fetch_valid,
    output logic               halted,
    output logic               misaligned
);

    localparam int         c_AW       = $clog2(MEM_BYTES);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_STALL = 2'd2;
    localparam logic [1:0] c_ST_HALT  = 2'd3;

    logic [1:0]      r_state;
    logic [c_AW-1:0] r_pc;
    logic            r_fv;
    logic            r_halted;
    logic            r_mis;
    logic            r_bubble;

    logic               w_redirect;
    logic [bitsDir-1:0] w_target;
    logic [c_AW-1:0]    w_tgt_pc;
    logic               w_tgt_mis;
    logic [c_AW-1:0]    w_pc_inc;
    logic               w_is_halt;
    logic               w_stall;
    logic               w_unused_bits;

    assign w_redirect = jump | branch_taken;
    assign w_target   = jump ? jump_target : branch_target;
    // Targets wrap modulo MEM_BYTES and are forced word-aligned.
    assign w_tgt_pc   = {w_target[c_AW-1:2], 2'b00};
    assign w_tgt_mis  = |w_target[1:0];
    assign w_pc_inc   = r_pc + c_AW'(4);
    assign w_is_halt  = (instruction == HALT_WORD);

`ifdef FETCH_STEP_EN
    assign w_stall = stall | (step_mode & ~step);
`else
    assign w_stall = stall;
`endif

    assign w_unused_bits = ^{jump_target[bitsDir-1:c_AW], branch_target[bitsDir-1:c_AW]};

    assign Addr        = {{(bitsDir-c_AW){1'b0}}, r_pc};
    assign pc_plus4    = {{(bitsDir-c_AW){1'b0}}, w_pc_inc};
    assign fetch_valid = r_fv;
    assign halted      = r_halted;
    assign misaligned  = r_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_pc     <= '0;
            r_fv     <= 1'b0;
            r_halted <= 1'b0;
            r_mis    <= 1'b0;
            r_bubble <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_state  <= c_ST_RUN;
                    r_fv     <= 1'b1;
                    r_bubble <= 1'b0;
                end
                c_ST_RUN, c_ST_STALL: begin
                    if (w_redirect) begin
                        r_state  <= c_ST_RUN;
                        r_pc     <= w_tgt_pc;
                        r_fv     <= 1'b0;
                        r_bubble <= 1'b1;
                        r_mis    <= r_mis | w_tgt_mis;
                    // The word presented during a flush bubble is stale, so it is never halt-checked.
                    end else if ((r_state == c_ST_RUN) && !r_bubble && w_is_halt) begin
                        r_state  <= c_ST_HALT;
                        r_fv     <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (w_stall) begin
                        r_state  <= c_ST_STALL;
                        r_fv     <= 1'b0;
                        r_bubble <= 1'b0;
                    end else if ((r_state == c_ST_STALL) || r_bubble) begin
                        r_state  <= c_ST_RUN;
                        r_fv     <= 1'b1;
                        r_bubble <= 1'b0;
                    end else begin
                        r_pc <= w_pc_inc;
                        r_fv <= 1'b1;
                    end
                end
                c_ST_HALT: begin
                    r_fv <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_fv    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Scoreboard bench for fetch_pc_unit: directed scenarios plus
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam int c_MEM = 128;
    localparam logic [31:0] c_HALT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] instruction = '0;
    logic [31:0] Addr;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        misaligned;
`ifdef FETCH_STEP_EN
    logic        step = 1'b0;
    logic        step_mode = 1'b0;
`endif

    fetch_pc_unit #(.bitsDir(32), .MEM_BYTES(c_MEM), .HALT_WORD(c_HALT)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instruction  (instruction),
`ifdef FETCH_STEP_EN
        .step         (step),
        .step_mode    (step_mode),
`endif
        .Addr         (Addr),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:c_MEM-1];

    function automatic logic [31:0] word_at(input int a);
        int b;
        b = a % c_MEM;
        return {mem[b], mem[(b+1)%c_MEM], mem[(b+2)%c_MEM], mem[(b+3)%c_MEM]};
    endfunction

    // Instruction memory: samples Addr on the falling edge, big-endian word out.
    always @(negedge clk) instruction <= word_at(int'(Addr[6:0]));

    typedef struct {
        int addr;
        bit valid;
        bit hlt;
        bit mis;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: abstract fetch status.
    typedef enum int {M_IDLE, M_RUN, M_STALL, M_HALT} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_pc = 0;
    bit      m_valid = 0, m_hlt = 0, m_mis = 0, m_fresh_redirect = 0;

    task automatic cyc(input bit rst, input bit stl, input bit jmp, input logic [31:0] jt,
                       input bit br, input logic [31:0] bt);
        logic [31:0] tgt;
        exp_t e;
        @(negedge clk);
        reset = rst; stall = stl; jump = jmp; jump_target = jt;
        branch_taken = br; branch_target = bt;
        tgt = jmp ? jt : bt;
        if (rst) begin
            m_phase = M_IDLE; m_pc = 0; m_valid = 0; m_hlt = 0; m_mis = 0; m_fresh_redirect = 0;
        end else if (m_phase == M_HALT) begin
            m_valid = 0;
        end else if (m_phase == M_IDLE) begin
            m_phase = M_RUN; m_valid = 1; m_fresh_redirect = 0;
        end else if (jmp || br) begin
            m_pc = int'(tgt % c_MEM) / 4 * 4;
            if (tgt % 4 != 0) m_mis = 1;
            m_valid = 0; m_phase = M_RUN; m_fresh_redirect = 1;
        end else if (m_phase == M_RUN && !m_fresh_redirect && word_at(m_pc) == c_HALT) begin
            m_phase = M_HALT; m_hlt = 1; m_valid = 0;
        end else if (stl) begin
            m_phase = M_STALL; m_valid = 0; m_fresh_redirect = 0;
        end else if (m_phase == M_STALL || m_fresh_redirect) begin
            m_phase = M_RUN; m_valid = 1; m_fresh_redirect = 0;
        end else begin
            m_pc = (m_pc + 4) % c_MEM; m_valid = 1;
        end
        e.addr = m_pc; e.valid = m_valid; e.hlt = m_hlt; e.mis = m_mis;
        q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill_safe();
        for (int i = 0; i < c_MEM; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < c_MEM; i += 4) mem[i] = 8'h13;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: one expectation per rising edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("Addr", Addr, 32'(e.addr));
                check("pc_plus4", pc_plus4, 32'((e.addr + 4) % c_MEM));
                check("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.valid});
                check("halted", {31'b0, halted}, {31'b0, e.hlt});
                check("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_safe();
        // Free run from reset.
        cyc(1, 0, 0, 0, 0, 0);
        run(6);
        // Stall at Addr 8.
        cyc(1, 0, 0, 0, 0, 0);
        run(3);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
        run(3);
        // Simultaneous jump and branch: jump wins.
        cyc(0, 0, 1, 32'h40, 1, 32'h20);
        run(3);
        // Misaligned branch target stays sticky.
        cyc(0, 0, 0, 0, 1, 32'h23);
        run(3);
        // Wrap-around increment and target.
        cyc(0, 0, 1, 32'h7C, 0, 0);
        run(3);
        cyc(0, 0, 1, 32'h90, 0, 0);
        run(2);
        // Halt word at Addr 12, then disturbance, then reset.
        cyc(1, 0, 0, 0, 0, 0);
        mem[12] = 8'hFF; mem[13] = 8'hFF; mem[14] = 8'hFF; mem[15] = 8'hFF;
        run(7);
        for (int i = 0; i < 6; i++)
            cyc(0, i[0], i[1], 32'h40, ~i[0], 32'h20);
        cyc(1, 0, 0, 0, 0, 0);
        run(3);
        // Halt word hit only through a redirect bubble must not halt.
        fill_safe();
        mem[32] = 8'hFF; mem[33] = 8'hFF; mem[34] = 8'hFF; mem[35] = 8'hFF;
        cyc(1, 0, 0, 0, 0, 0);
        run(2);
        cyc(0, 0, 1, 32'h20, 0, 0);
        cyc(0, 0, 1, 32'h40, 0, 0);
        run(2);

        // Randomized segments.
        for (int s = 0; s < 20; s++) begin
            fill_safe();
            for (int w = 0; w < c_MEM; w += 4)
                if ($urandom_range(0, 24) == 0) begin
                    mem[w] = 8'hFF; mem[w+1] = 8'hFF; mem[w+2] = 8'hFF; mem[w+3] = 8'hFF;
                end
            cyc(1, 0, 0, 0, 0, 0);
            for (int i = 0; i < 100; i++) begin
                automatic bit rr = ($urandom_range(0, 99) == 0);
                automatic bit ss = ($urandom_range(0, 4) == 0);
                automatic bit jj = ($urandom_range(0, 15) == 0);
                automatic bit bb = ($urandom_range(0, 15) == 0);
                automatic logic [31:0] jt = (s % 2 == 0) ? $urandom() : 32'($urandom_range(0, 255));
                automatic logic [31:0] bt = (s % 3 == 0) ? $urandom() : 32'($urandom_range(0, 255)) & ~32'h3;
                cyc(rr, ss, jj, jt, bb, bt);
            end
        end

        cyc(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
